// File: rtl/sdpram_fifo_ctrl.sv
// rtl/sdpram_fifo_ctrl.sv - FIFO controller driving an external simple dual-port RAM with a registered output word
module sdpram_fifo_ctrl #(
    parameter int  DATA_WIDTH = 32,
    parameter int  MEM_DEPTH  = 1024,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic [STRB_WIDTH-1:0] wena,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dina,
    output logic                  renb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0]   addra_q;
    logic [ADDR_WIDTH-1:0]   addrb_q;
    logic [DATA_WIDTH-1:0]   dina_q;
    logic [ADDR_WIDTH:0]     mem_count;
    logic                    push;
    logic                    rd_issue;
    logic                    mem_avail;
    logic                    out_busy;

    assign full      = (mem_count == MEM_FULL);
    assign s_ready   = !full;
    assign mem_avail = (mem_count != '0);

    // rst gating keeps the RAM strobes quiet the instant reset asserts, before any edge
    assign push     = rst && s_valid && s_ready;
    assign rd_issue = rst && mem_avail &&
                      ((state == IDLE) || ((state == VALID) && m_ready));

    assign wena  = {STRB_WIDTH{push}};
    assign addra = push ? wr_ptr : addra_q;
    assign dina  = push ? s_data : dina_q;

    assign renb  = rd_issue;
    assign addrb = rd_issue ? rd_ptr : addrb_q;

    assign m_valid  = (state == VALID);
    assign out_busy = (state != IDLE);
    assign count    = mem_count + {{ADDR_WIDTH{1'b0}}, out_busy};
    assign empty    = (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            addra_q <= '0;
            dina_q  <= '0;
        end else if (push) begin
            wr_ptr  <= wr_ptr + ADDR_WIDTH'(1);
            addra_q <= wr_ptr;
            dina_q  <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            addrb_q <= '0;
        end else if (rd_issue) begin
            rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
            addrb_q <= rd_ptr;
        end
    end

    // A push and a read issue in the same cycle cancel out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_count <= '0;
        end else if (push && !rd_issue) begin
            mem_count <= mem_count + (ADDR_WIDTH + 1)'(1);
        end else if (!push && rd_issue) begin
            mem_count <= mem_count - (ADDR_WIDTH + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            m_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_issue) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    m_data <= doutb;
                    state  <= VALID;
                end
                VALID: begin
                    if (m_ready) begin
                        state <= rd_issue ? FETCH : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// tb/tb_sdpram_fifo_ctrl.sv - scoreboard bench for sdpram_fifo_ctrl with a behavioural RAM and queue model
module tb_sdpram_fifo_ctrl;

    localparam int D = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [10:0] count;
    logic        full;
    logic        empty;
    logic [3:0]  wena;
    logic [9:0]  addra;
    logic [31:0] dina;
    logic        renb;
    logic [9:0]  addrb;
    logic [31:0] doutb = '0;

    logic [31:0] ram [D];

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    int n_push = 0;
    int n_pop  = 0;
    int n_rd   = 0;

    sdpram_fifo_ctrl dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .full(full), .empty(empty),
        .wena(wena), .addra(addra), .dina(dina),
        .renb(renb), .addrb(addrb), .doutb(doutb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wena != 4'h0) ram[addra] <= dina;
        if (renb) doutb <= ram[addrb];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every DUT cycle against the word-level model
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            n_push = 0;
            n_pop  = 0;
            n_rd   = 0;
        end else begin
            chk("count", 64'(count), 64'(n_push - n_pop));
            chk("empty", 64'(empty), 64'(n_push == n_pop));
            chk("full", 64'(full), 64'((n_push - n_rd) == D));
            chk("s_ready", 64'(s_ready), 64'((n_push - n_rd) != D));
            if (renb) begin
                chk("addrb", 64'(addrb), 64'(n_rd % D));
                chk("read_avail", 64'(n_rd < n_push), 64'(1));
                n_rd++;
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("m_valid_no_word", 64'(m_valid), 64'(0));
                end else begin
                    chk("m_data", 64'(m_data), 64'(exp_q[0]));
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        n_pop++;
                    end
                end
            end
            if (s_valid && s_ready) begin
                chk("wena", 64'(wena), 64'(4'hF));
                chk("addra", 64'(addra), 64'(n_push % D));
                chk("dina", 64'(dina), 64'(s_data));
                exp_q.push_back(s_data);
                n_push++;
            end else begin
                chk("wena_idle", 64'(wena), 64'(0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done = 0;
        tick();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            if (count == '0) done = 1;
            else tick();
        end
        chk("drain_done", 64'(done), 64'(1));
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        int pushed;
        int guard;
        bit seen;

        // Reset and idle
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(1));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_renb", 64'(renb), 64'(0));

        // Single word latency from empty
        tick();
        s_valid = 1'b1;
        s_data  = 32'h1234_5678;
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        chk("lat_renb_n1", 64'(renb), 64'(1));
        chk("lat_addrb_n1", 64'(addrb), 64'(0));
        tick();
        @(negedge clk);
        chk("lat_m_valid_n2", 64'(m_valid), 64'(0));
        tick();
        @(negedge clk);
        chk("lat_m_valid_n3", 64'(m_valid), 64'(1));
        chk("lat_m_data_n3", 64'(m_data), 64'(32'h1234_5678));
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Five words held with m_ready low
        for (int k = 1; k <= 5; k++) begin
            tick();
            s_valid = 1'b1;
            s_data  = 32'hA5A5_0000 + 32'(k);
            @(negedge clk);
            chk("five_wena", 64'(wena), 64'(4'hF));
        end
        tick();
        s_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("five_count", 64'(count), 64'(5));
        chk("five_m_valid", 64'(m_valid), 64'(1));
        chk("five_m_data", 64'(m_data), 64'(32'hA5A5_0001));
        repeat (5) tick();
        @(negedge clk);
        chk("five_m_data_held", 64'(m_data), 64'(32'hA5A5_0001));
        drain();

        // Fill to full
        pushed = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            s_valid = 1'b1;
            s_data  = 32'hB000_0000 + 32'(pushed);
            @(negedge clk);
            if (s_ready) pushed++;
            else break;
        end
        chk("fill_pushed", 64'(pushed), 64'(1025));
        chk("fill_count", 64'(count), 64'(1025));
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_s_ready", 64'(s_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            s_data = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("fill_no_write", 64'(wena), 64'(0));
        end
        drain();

        // Random streaming across pointer wrap
        pushed = 0;
        guard  = 0;
        while (pushed < 2000 && guard < 20000) begin
            tick();
            s_valid = ($urandom % 4) != 0;
            s_data  = 32'h5000_0000 + 32'(pushed);
            m_ready = $urandom_range(0, 1) == 1;
            @(negedge clk);
            if (s_valid && s_ready) pushed++;
            guard++;
        end
        chk("stream_pushed", 64'(pushed), 64'(2000));
        drain();
        chk("stream_q_empty", 64'(exp_q.size()), 64'(0));

        // Reset while a read is in flight
        for (int k = 0; k < 3; k++) begin
            tick();
            s_valid = 1'b1;
            s_data  = 32'hC0DE_0000 + 32'(k);
        end
        tick();
        s_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (m_valid) seen = 1;
            else tick();
        end
        chk("rst_mid_valid", 64'(seen), 64'(1));
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_renb", 64'(renb), 64'(1));
        tick();
        m_ready = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("rstm_count", 64'(count), 64'(0));
        chk("rstm_empty", 64'(empty), 64'(1));
        chk("rstm_full", 64'(full), 64'(0));
        chk("rstm_m_valid", 64'(m_valid), 64'(0));
        chk("rstm_m_data", 64'(m_data), 64'(0));
        chk("rstm_renb", 64'(renb), 64'(0));
        chk("rstm_wena", 64'(wena), 64'(0));
        chk("rstm_addra", 64'(addra), 64'(0));
        chk("rstm_addrb", 64'(addrb), 64'(0));
        chk("rstm_dina", 64'(dina), 64'(0));
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_m_valid", 64'(m_valid), 64'(0));
            chk("post_rst_m_data", 64'(m_data), 64'(0));
            tick();
        end
        s_valid = 1'b1;
        s_data  = 32'h7777_0001;
        tick();
        s_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("post_rst_word", 64'(m_data), 64'(32'h7777_0001));
        drain();
        chk("final_q_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
